// File: rtl/tt_bist_pkg.sv
// Shared types and default polynomials for the Tiny Tapeout BIST harness.
package tt_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_LFSR = 2'd0,
    MODE_CNT  = 2'd1,
    MODE_WALK = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  localparam logic [7:0]  LFSR_POLY_8  = 8'h1D;
  localparam logic [15:0] MISR_POLY_16 = 16'h002D;

endpackage

// File: rtl/tt_bist_galois_step.sv
// One combinational Galois shift step with an XOR input word (LFSR when din is 0, MISR otherwise).
module tt_bist_galois_step #(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  POLY = '0
) (
  input  logic [W-1:0] state,
  input  logic [W-1:0] din,
  output logic [W-1:0] next_c
);

  assign next_c = {state[W-2:0], 1'b0} ^ (state[W-1] ? POLY : '0) ^ din;

endmodule

// File: rtl/tt_bist_harness.sv
// Built-in self-test harness: drives pattern vectors, compresses masked DUT outputs
// into a MISR and compares the final signature with a golden value.
module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int unsigned      IN_W      = 8,
  parameter int unsigned      OUT_W     = 16,
  parameter int unsigned      CNT_W     = 12,
  parameter int unsigned      SETTLE_W  = 4,
  parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(LFSR_POLY_8),
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(MISR_POLY_16)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [IN_W-1:0]     seed,
  input  logic [CNT_W-1:0]    n_vectors,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [OUT_W-1:0]    expected_sig,
  input  logic [OUT_W-1:0]    dut_out,
  input  logic [OUT_W-1:0]    dut_oe,
  output logic [IN_W-1:0]     stim_out,
  output logic                stim_valid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [OUT_W-1:0]    signature
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [IN_W-1:0]     pattern_q, pattern_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [OUT_W-1:0]    misr_q, misr_d;
  logic [IN_W-1:0]     stim_out_q, stim_out_d;
  logic                stim_valid_q, stim_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [OUT_W-1:0]    signature_q, signature_d;

  logic [IN_W-1:0]     lfsr_next_c;
  logic [OUT_W-1:0]    misr_next_c;
  logic [IN_W-1:0]     pattern_adv_c;
  logic                running_c;

  tt_bist_galois_step #(.W(IN_W), .POLY(LFSR_POLY)) u_lfsr_step (
    .state  (pattern_q),
    .din    ('0),
    .next_c (lfsr_next_c)
  );

  tt_bist_galois_step #(.W(OUT_W), .POLY(MISR_POLY)) u_misr_step (
    .state  (misr_q),
    .din    (dut_out & dut_oe),
    .next_c (misr_next_c)
  );

  always_comb begin
    unique case (mode_q)
      MODE_LFSR: pattern_adv_c = lfsr_next_c;
      MODE_CNT:  pattern_adv_c = pattern_q + IN_W'(1);
      MODE_WALK: pattern_adv_c = {pattern_q[IN_W-2:0], pattern_q[IN_W-1]};
      default:   pattern_adv_c = pattern_q;
    endcase
  end

  // Next-state and registered-output computation; outputs track the state being entered.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pattern_d    = pattern_q;
    n_d          = n_q;
    vec_cnt_d    = vec_cnt_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    misr_d       = misr_q;
    pass_d       = pass_q;
    signature_d  = signature_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          mode_d       = mode_e'(mode);
          n_d          = n_vectors;
          settle_d     = settle;
          settle_cnt_d = settle;
          vec_cnt_d    = '0;
          misr_d       = '0;
          pass_d       = 1'b0;
          signature_d  = '0;
          unique case (mode_e'(mode))
            MODE_LFSR: pattern_d = (seed == '0) ? IN_W'(1) : seed;
            MODE_WALK: pattern_d = IN_W'(1);
            default:   pattern_d = seed;
          endcase
          state_d = (n_vectors != '0) ? ST_APPLY : ST_FINISH;
        end
      end
      ST_APPLY: begin
        if (settle_cnt_q == '0) state_d = ST_CAPTURE;
        else                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
      end
      ST_CAPTURE: begin
        misr_d    = misr_next_c;
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
        pattern_d = pattern_adv_c;
        if (vec_cnt_q == n_q - CNT_W'(1)) begin
          state_d = ST_FINISH;
        end else begin
          settle_cnt_d = settle_q;
          state_d      = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d      = ST_IDLE;
      pattern_d    = '0;
      vec_cnt_d    = '0;
      settle_cnt_d = '0;
      misr_d       = '0;
      pass_d       = 1'b0;
      signature_d  = '0;
    end

    running_c    = (state_d == ST_APPLY) || (state_d == ST_CAPTURE);
    stim_out_d   = running_c ? pattern_d : '0;
    stim_valid_d = running_c;
    busy_d       = running_c;
    done_d       = (state_d == ST_FINISH);
    if (state_d == ST_FINISH) begin
      signature_d = misr_d;
      pass_d      = (misr_d == expected_sig);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_LFSR;
      pattern_q    <= '0;
      n_q          <= '0;
      vec_cnt_q    <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      misr_q       <= '0;
      stim_out_q   <= '0;
      stim_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      signature_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      n_q          <= n_d;
      vec_cnt_q    <= vec_cnt_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      misr_q       <= misr_d;
      stim_out_q   <= stim_out_d;
      stim_valid_q <= stim_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      signature_q  <= signature_d;
    end
  end

  assign stim_out   = stim_out_q;
  assign stim_valid = stim_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = signature_q;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Self-checking bench for tt_bist_harness: directed table, hand-written abort/reset
// sequences and randomized runs against a per-cycle reference model.
module tb_tt_bist_harness;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [11:0] n_vectors;
  logic [3:0]  settle;
  logic [15:0] expected_sig, dut_out, dut_oe;
  logic [7:0]  stim_out;
  logic        stim_valid, busy, done, pass;
  logic [15:0] signature;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tt_bist_harness dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .n_vectors(n_vectors), .settle(settle), .expected_sig(expected_sig),
    .dut_out(dut_out), .dut_oe(dut_oe), .stim_out(stim_out), .stim_valid(stim_valid),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] p);
    return {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [15:0] misr_adv(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ d;
  endfunction

  // Vector number v of a run, derived directly from the pattern rules.
  function automatic logic [7:0] vec_at(input logic [1:0] md, input logic [7:0] sd, input int v);
    logic [7:0] p;
    case (md)
      2'd0: begin
        p = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < v; i++) p = lfsr_adv(p);
      end
      2'd1:    p = 8'(int'(sd) + v);
      2'd2:    p = 8'(1 << (v % 8));
      default: p = sd;
    endcase
    return p;
  endfunction

  function automatic logic [27:0] outs();
    return {stim_out, stim_valid, busy, done, pass, signature};
  endfunction

  // esel: 0 use esig_in, 1 use model signature, 2 model signature with one bit flipped.
  task automatic run(input logic [1:0] md, input logic [7:0] sd, input int nv, input int st,
                     input int esel, input logic [15:0] esig_in, input bit rnd,
                     input logic [15:0] cdo, input logic [15:0] coe,
                     output int done_cyc, output logic [7:0] v0, output logic [7:0] v1);
    logic [15:0] dout [MAXC];
    logic [15:0] doe  [MAXC];
    logic [15:0] m, es;
    logic        ep, run_ph;
    logic [7:0]  ev;
    logic [27:0] exp_w;
    int          per, t;
    per = st + 2;
    t   = nv * per + 1;
    for (int c = 1; c <= t + 1; c++) begin
      dout[c] = rnd ? 16'($urandom) : cdo;
      doe[c]  = rnd ? 16'($urandom) : coe;
    end
    m = 16'h0;
    for (int c = 1; c < t; c++)
      if ((c - 1) % per == per - 1) m = misr_adv(m, dout[c] & doe[c]);
    es = (esel == 0) ? esig_in : (esel == 1) ? m : (m ^ 16'(1 << $urandom_range(0, 15)));
    ep = (es == m);
    done_cyc = -1; v0 = 8'h00; v1 = 8'h00;

    mode = md; seed = sd; n_vectors = 12'(nv); settle = 4'(st);
    expected_sig = es; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (rnd) begin
      mode = 2'($urandom); seed = 8'($urandom);
      n_vectors = 12'($urandom); settle = 4'($urandom);
    end
    for (int c = 1; c <= t + 1; c++) begin
      run_ph = (c < t);
      ev     = run_ph ? vec_at(md, sd, (c - 1) / per) : 8'h00;
      exp_w  = {ev, run_ph, run_ph, (c == t), (c >= t) ? ep : 1'b0, (c >= t) ? m : 16'h0};
      chk($sformatf("cycle%0d_m%0d_n%0d_s%0d", c, md, nv, st), 64'(outs()), 64'(exp_w));
      if (done && done_cyc < 0) done_cyc = c;
      if (c == 1) v0 = stim_out;
      if (c == per + 1) v1 = stim_out;
      dut_out = dout[c];
      dut_oe  = doe[c];
      start   = rnd && (c <= t) && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [7:0]  sd;
    int          nv;
    int          st;
    logic [15:0] dout;
    logic [15:0] doe;
    logic [15:0] esig;
    logic [15:0] x_sig;
    logic        x_pass;
    int          x_done;
    logic [7:0]  x_v0;
    logic [7:0]  x_v1;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          dc;
    logic [7:0]  v0, v1;
    bit          seen_done;

    tbl[0] = '{2'd1, 8'h00, 4, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1,  9, 8'h00, 8'h01};
    tbl[1] = '{2'd3, 8'h5A, 2, 0, 16'h0001, 16'hFFFF, 16'h0003, 16'h0003, 1'b1,  5, 8'h5A, 8'h5A};
    tbl[2] = '{2'd3, 8'h5A, 2, 0, 16'h0001, 16'hFFFF, 16'h0004, 16'h0003, 1'b0,  5, 8'h5A, 8'h5A};
    tbl[3] = '{2'd0, 8'h80, 2, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1,  5, 8'h80, 8'h1D};
    tbl[4] = '{2'd0, 8'h00, 2, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1,  5, 8'h01, 8'h02};
    tbl[5] = '{2'd2, 8'hAA, 9, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 37, 8'h01, 8'h02};
    tbl[6] = '{2'd1, 8'h33, 0, 3, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 1'b1,  1, 8'h00, 8'h00};
    tbl[7] = '{2'd1, 8'hFF, 3, 1, 16'h00FF, 16'h0F0F, 16'h002D, 16'h002D, 1'b1, 10, 8'hFF, 8'h00};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; seed = 8'h00;
    n_vectors = 12'd0; settle = 4'd0; expected_sig = 16'h0; dut_out = 16'h0; dut_oe = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outputs", 64'(outs()), 64'h0);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].md, tbl[i].sd, tbl[i].nv, tbl[i].st, 0, tbl[i].esig, 1'b0,
          tbl[i].dout, tbl[i].doe, dc, v0, v1);
      chk($sformatf("tbl%0d_signature", i), 64'(signature), 64'(tbl[i].x_sig));
      chk($sformatf("tbl%0d_pass", i), 64'(pass), 64'(tbl[i].x_pass));
      chk($sformatf("tbl%0d_done_cycle", i), 64'(dc), 64'(tbl[i].x_done));
      chk($sformatf("tbl%0d_vec0", i), 64'(v0), 64'(tbl[i].x_v0));
      chk($sformatf("tbl%0d_vec1", i), 64'(v1), 64'(tbl[i].x_v1));
    end

    // Abort at cycle 3 of a 4-vector run, with an extra start during the run.
    mode = 2'd1; seed = 8'h00; n_vectors = 12'd4; settle = 4'd0; expected_sig = 16'h0;
    dut_out = 16'hFFFF; dut_oe = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("abort_pre_state", 64'({stim_out, stim_valid, busy, done}), 64'({8'h01, 1'b1, 1'b1, 1'b0}));
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_idle", 64'(outs()), 64'h0);
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(seen_done), 64'h0);

    // Leave a nonzero held signature, then reset in the middle of a run.
    run(2'd3, 8'h00, 2, 0, 1, 16'h0, 1'b0, 16'h0001, 16'hFFFF, dc, v0, v1);
    chk("pre_rst_signature", 64'(signature), 64'h0003);
    mode = 2'd3; seed = 8'h3C; n_vectors = 12'd3; settle = 4'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_apply", 64'({stim_out, busy, signature}), 64'({8'h3C, 1'b1, 16'h0}));
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_mid_run", 64'(outs()), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_stays_idle", 64'(outs()), 64'h0);

    for (int r = 0; r < 30; r++) begin
      run(2'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
          $urandom_range(0, 12), $urandom_range(0, 6), 1 + (r % 2), 16'h0, 1'b1,
          16'h0, 16'h0, dc, v0, v1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
